// File: rtl/sprite_rom_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sprite_rom_reader_pkg
// Description : Shared constants and types for the sprite ROM reader.
//               Holds the default sprite geometry, the {r,g,b} 12-bit colour
//               field layout and the pixel pipeline depth. Other overlays use
//               the depth to stay aligned with this block.
// Revision    : 1.0 - initial release
// ============================================================================
package sprite_rom_reader_pkg;

  localparam int c_SPRITE_W_DEF = 20;
  localparam int c_SPRITE_H_DEF = 18;

  // Input sample to output register, in clocks.
  localparam int c_PIPE_DEPTH = 4;

  // {r,g,b} 4-bit field positions inside a 12-bit colour.
  localparam int c_RGB_R_HI = 11;
  localparam int c_RGB_R_LO = 8;
  localparam int c_RGB_G_HI = 7;
  localparam int c_RGB_G_LO = 4;
  localparam int c_RGB_B_HI = 3;
  localparam int c_RGB_B_LO = 0;

  // Bit positions inside the {de, hsync, vsync} control bundle.
  localparam int c_CTL_DE = 2;
  localparam int c_CTL_HS = 1;
  localparam int c_CTL_VS = 0;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  // Only the low nibble of each ROM byte carries colour.
  function automatic rgb12_t rgb12_from_rom(input logic [3:0] r,
                                            input logic [3:0] g,
                                            input logic [3:0] b);
    logic [11:0] w_pix;
    w_pix                        = '0;
    w_pix[c_RGB_R_HI:c_RGB_R_LO] = r;
    w_pix[c_RGB_G_HI:c_RGB_G_LO] = g;
    w_pix[c_RGB_B_HI:c_RGB_B_LO] = b;
    return rgb12_t'(w_pix);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_box_test.sv
`default_nettype none
// ============================================================================
// Module      : sprite_box_test
// Description : Combinational sprite bounding-box test. Reports whether a
//               displayed pixel lies inside a (possibly magnified) sprite box
//               and gives the texel row/column it maps to.
//   de_i, en_i          : display enable, sprite visibility
//   pix_x_i, pix_y_i    : current pixel position
//   pos_x_i, pos_y_i    : sprite top-left corner in screen pixels
//   in_box_o            : pixel hits the sprite box
//   row_o, col_o        : texel coordinates (0 when outside the box)
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_box_test #(
  parameter int SPRITE_W   = 20,
  parameter int SPRITE_H   = 18,
  parameter int SCALE_LOG2 = 0,
  parameter int ROW_W      = 5,
  parameter int COL_W      = 5
) (
  input  logic             de_i,
  input  logic             en_i,
  input  logic [9:0]       pix_x_i,
  input  logic [9:0]       pix_y_i,
  input  logic [9:0]       pos_x_i,
  input  logic [9:0]       pos_y_i,
  output logic             in_box_o,
  output logic [ROW_W-1:0] row_o,
  output logic [COL_W-1:0] col_o
);

  localparam logic [10:0] c_BOX_W = 11'(SPRITE_W << SCALE_LOG2);
  localparam logic [10:0] c_BOX_H = 11'(SPRITE_H << SCALE_LOG2);

  logic [10:0] w_x_end;
  logic [10:0] w_y_end;
  logic [9:0]  w_dx;
  logic [9:0]  w_dy;
  logic        w_in_x;
  logic        w_in_y;

  always_comb begin
    // 11-bit end coordinates: a box hanging off the right/bottom edge is
    // clipped instead of wrapping back to column/row 0.
    w_x_end  = {1'b0, pos_x_i} + c_BOX_W;
    w_y_end  = {1'b0, pos_y_i} + c_BOX_H;
    w_in_x   = (pix_x_i >= pos_x_i) && ({1'b0, pix_x_i} < w_x_end);
    w_in_y   = (pix_y_i >= pos_y_i) && ({1'b0, pix_y_i} < w_y_end);
    w_dx     = pix_x_i - pos_x_i;
    w_dy     = pix_y_i - pos_y_i;
    in_box_o = de_i & en_i & w_in_x & w_in_y;
    // Inside the box the shifted offsets always fit the texel widths.
    col_o    = in_box_o ? COL_W'(w_dx >> SCALE_LOG2) : '0;
    row_o    = in_box_o ? ROW_W'(w_dy >> SCALE_LOG2) : '0;
  end

endmodule
`default_nettype wire

// File: rtl/sprite_rom_reader.sv
`default_nettype none
// ============================================================================
// Module      : sprite_rom_reader
// Description : Raster-side sprite reader. Tests each pixel against a
//               frame-latched sprite box and addresses the shared r/g/b
//               sprite ROMs, which have a 1-cycle registered read. It then
//               composites the texel over the background with colour-key
//               transparency. Syncs and display enable are delayed to match.
//   clock, reset_n              : pixel clock, async active-low reset
//   frame_start                 : latches sprite_x/y/en for the new frame
//   de_in, hsync_in, vsync_in   : timing generator controls
//   pixel_x, pixel_y, bg_rgb    : current pixel and its background colour
//   sprite_x, sprite_y, sprite_en : requested sprite placement
//   rom_address                 : shared ROM address (registered)
//   rom_r, rom_g, rom_b         : ROM read data (low nibble used)
//   de_out, hsync_out, vsync_out: controls delayed by the pipeline depth
//   rgb_out, sprite_hit         : composited colour, opaque texel flag
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_rom_reader
  import sprite_rom_reader_pkg::*;
#(
  parameter int          SPRITE_W   = c_SPRITE_W_DEF,
  parameter int          SPRITE_H   = c_SPRITE_H_DEF,
  parameter int          SCALE_LOG2 = 0,
  parameter logic [11:0] KEY_RGB    = 12'hFFF,
  parameter int          ADDR_W     = 9
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              frame_start,
  input  logic              de_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic [11:0]       bg_rgb,
  input  logic [9:0]        sprite_x,
  input  logic [9:0]        sprite_y,
  input  logic              sprite_en,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [7:0]        rom_r,
  input  logic [7:0]        rom_g,
  input  logic [7:0]        rom_b,
  output logic              de_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic [11:0]       rgb_out,
  output logic              sprite_hit
);

  localparam int ROW_W = $clog2(SPRITE_H);
  localparam int COL_W = $clog2(SPRITE_W);

  // Active sprite position: the _d value is what the current pixel sees, so
  // a pixel coincident with frame_start already uses the new placement.
  logic [9:0] x_act_q, x_act_d;
  logic [9:0] y_act_q, y_act_d;
  logic       en_act_q, en_act_d;

  always_comb begin
    x_act_d  = x_act_q;
    y_act_d  = y_act_q;
    en_act_d = en_act_q;
    if (frame_start) begin
      x_act_d  = sprite_x;
      y_act_d  = sprite_y;
      en_act_d = sprite_en;
    end
  end

  logic             box_hit_d;
  logic [ROW_W-1:0] box_row_d;
  logic [COL_W-1:0] box_col_d;

  sprite_box_test #(
    .SPRITE_W   (SPRITE_W),
    .SPRITE_H   (SPRITE_H),
    .SCALE_LOG2 (SCALE_LOG2),
    .ROW_W      (ROW_W),
    .COL_W      (COL_W)
  ) u_box_test (
    .de_i     (de_in),
    .en_i     (en_act_d),
    .pix_x_i  (pixel_x),
    .pix_y_i  (pixel_y),
    .pos_x_i  (x_act_d),
    .pos_y_i  (y_act_d),
    .in_box_o (box_hit_d),
    .row_o    (box_row_d),
    .col_o    (box_col_d)
  );

  // Stage registers. The {de,hsync,vsync} bundle rides a shift line whose
  // last tap is the output; the tap before it qualifies the final colour.
  logic             in_box_s1_q, in_box_s2_q, in_box_s3_q;
  logic [ROW_W-1:0] row_s1_q;
  logic [COL_W-1:0] col_s1_q;
  logic [11:0]      bg_s1_q, bg_s2_q, bg_s3_q;
  logic [ADDR_W-1:0] rom_address_q, rom_address_d;
  logic [2:0]       ctl_q [c_PIPE_DEPTH];
  logic [11:0]      rgb_q, rgb_d;
  logic             hit_q, hit_d;
  rgb12_t           tex_d;
  logic             de_s3;

  // High ROM nibbles are not colour data.
  logic w_unused_rom_hi;
  assign w_unused_rom_hi = &{rom_r[7:4], rom_g[7:4], rom_b[7:4]};

  always_comb begin
    rom_address_d = in_box_s1_q
                  ? ADDR_W'(int'(row_s1_q) * SPRITE_W + int'(col_s1_q))
                  : '0;
    de_s3  = ctl_q[c_PIPE_DEPTH-2][c_CTL_DE];
    tex_d  = rgb12_from_rom(rom_r[3:0], rom_g[3:0], rom_b[3:0]);
    hit_d  = in_box_s3_q && (tex_d != KEY_RGB);
    rgb_d  = !de_s3 ? 12'h000 : (hit_d ? 12'(tex_d) : bg_s3_q);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x_act_q       <= '0;
      y_act_q       <= '0;
      en_act_q      <= 1'b0;
      in_box_s1_q   <= 1'b0;
      in_box_s2_q   <= 1'b0;
      in_box_s3_q   <= 1'b0;
      row_s1_q      <= '0;
      col_s1_q      <= '0;
      bg_s1_q       <= '0;
      bg_s2_q       <= '0;
      bg_s3_q       <= '0;
      rom_address_q <= '0;
      rgb_q         <= '0;
      hit_q         <= 1'b0;
      for (int i = 0; i < c_PIPE_DEPTH; i++) ctl_q[i] <= '0;
    end else begin
      x_act_q       <= x_act_d;
      y_act_q       <= y_act_d;
      en_act_q      <= en_act_d;
      in_box_s1_q   <= box_hit_d;
      row_s1_q      <= box_row_d;
      col_s1_q      <= box_col_d;
      bg_s1_q       <= bg_rgb;
      in_box_s2_q   <= in_box_s1_q;
      bg_s2_q       <= bg_s1_q;
      rom_address_q <= rom_address_d;
      // ROM captures rom_address_q on this edge; carry the sidebands with it.
      in_box_s3_q   <= in_box_s2_q;
      bg_s3_q       <= bg_s2_q;
      rgb_q         <= rgb_d;
      hit_q         <= hit_d;
      ctl_q[0]      <= {de_in, hsync_in, vsync_in};
      for (int i = 1; i < c_PIPE_DEPTH; i++) ctl_q[i] <= ctl_q[i-1];
    end
  end

  assign rom_address = rom_address_q;
  assign rgb_out     = rgb_q;
  assign sprite_hit  = hit_q;
  assign de_out      = ctl_q[c_PIPE_DEPTH-1][c_CTL_DE];
  assign hsync_out   = ctl_q[c_PIPE_DEPTH-1][c_CTL_HS];
  assign vsync_out   = ctl_q[c_PIPE_DEPTH-1][c_CTL_VS];

endmodule
`default_nettype wire

// File: tb/tb_sprite_rom_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_rom_reader
// Description : Self-checking bench. Two readers (1x and 2x magnification)
//               share one randomized pixel stream, each with its own
//               registered-read ROM model. Expected outputs come from a
//               per-pixel arithmetic model of the sprite box and compositing
//               rules, queued by cycle and compared after the pipeline delay.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_rom_reader;

  localparam int          N_CYC = 2048;
  localparam logic [11:0] KEY   = 12'hFFF;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n = 1'b0, frame_start = 1'b0, de_in = 1'b0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, sprite_en = 1'b0;
  logic [9:0]  pixel_x = '0, pixel_y = '0, sprite_x = '0, sprite_y = '0;
  logic [11:0] bg_rgb = '0;

  logic [8:0]  a0, a1;
  logic [7:0]  rr0, rg0, rb0, rr1, rg1, rb1;
  logic        de0, hs0, vs0, hit0, de1, hs1, vs1, hit1;
  logic [11:0] rgb0, rgb1;

  logic [7:0] mem_r [512];
  logic [7:0] mem_g [512];
  logic [7:0] mem_b [512];

  sprite_rom_reader #(.SCALE_LOG2(0)) u_dut_s0 (
    .clock(clock), .reset_n(reset_n), .frame_start(frame_start),
    .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .bg_rgb(bg_rgb),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_en(sprite_en),
    .rom_address(a0), .rom_r(rr0), .rom_g(rg0), .rom_b(rb0),
    .de_out(de0), .hsync_out(hs0), .vsync_out(vs0),
    .rgb_out(rgb0), .sprite_hit(hit0)
  );

  sprite_rom_reader #(.SCALE_LOG2(1)) u_dut_s1 (
    .clock(clock), .reset_n(reset_n), .frame_start(frame_start),
    .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .bg_rgb(bg_rgb),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_en(sprite_en),
    .rom_address(a1), .rom_r(rr1), .rom_g(rg1), .rom_b(rb1),
    .de_out(de1), .hsync_out(hs1), .vsync_out(vs1),
    .rgb_out(rgb1), .sprite_hit(hit1)
  );

  // Registered-read ROM models.
  always @(posedge clock) begin
    rr0 <= mem_r[a0]; rg0 <= mem_g[a0]; rb0 <= mem_b[a0];
    rr1 <= mem_r[a1]; rg1 <= mem_g[a1]; rb1 <= mem_b[a1];
  end

  // Expected results indexed by the cycle the pixel was driven.
  logic [11:0] e_rgb  [2][N_CYC];
  logic        e_hit  [2][N_CYC];
  logic [8:0]  e_addr [2][N_CYC];
  logic [2:0]  e_ctl  [N_CYC];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int act_x = 0, act_y = 0;
  bit act_en = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic clear_exp(input int c);
    for (int d = 0; d < 2; d++) begin
      e_rgb[d][c]  = '0;
      e_hit[d][c]  = 1'b0;
      e_addr[d][c] = '0;
    end
    e_ctl[c] = '0;
  endtask

  task automatic step(input logic rn, input logic fs, input logic de,
                      input logic hs, input logic vs, input int px, input int py,
                      input logic [11:0] bg, input int sx, input int sy,
                      input logic sen);
    if (cyc >= N_CYC) begin
      check_eq("cycle_budget", cyc, N_CYC - 1);
      return;
    end
    @(negedge clock);
    if (cyc >= 4) begin
      check_eq("rgb_s0", rgb0, e_rgb[0][cyc-4]);
      check_eq("hit_s0", hit0, e_hit[0][cyc-4]);
      check_eq("ctl_s0", {de0, hs0, vs0}, e_ctl[cyc-4]);
      check_eq("rgb_s1", rgb1, e_rgb[1][cyc-4]);
      check_eq("hit_s1", hit1, e_hit[1][cyc-4]);
      check_eq("ctl_s1", {de1, hs1, vs1}, e_ctl[cyc-4]);
    end
    if (cyc >= 2) begin
      check_eq("addr_s0", a0, e_addr[0][cyc-2]);
      check_eq("addr_s1", a1, e_addr[1][cyc-2]);
    end
    if (!rn && reset_n) begin
      // Reset wipes everything still in flight.
      reset_n = 1'b0;
      for (int c = cyc - 3; c < cyc; c++) if (c >= 0) clear_exp(c);
      #1;
      check_eq("async_rst_s0", {rgb0, hit0, de0, hs0, vs0, a0}, 0);
      check_eq("async_rst_s1", {rgb1, hit1, de1, hs1, vs1, a1}, 0);
    end
    reset_n     = rn;
    frame_start = fs;
    de_in       = de;
    hsync_in    = hs;
    vsync_in    = vs;
    pixel_x     = 10'(px);
    pixel_y     = 10'(py);
    bg_rgb      = bg;
    sprite_x    = 10'(sx);
    sprite_y    = 10'(sy);
    sprite_en   = sen;

    if (!rn) begin
      act_x = 0; act_y = 0; act_en = 1'b0;
      clear_exp(cyc);
    end else begin
      if (fs) begin
        act_x = sx; act_y = sy; act_en = sen;
      end
      e_ctl[cyc] = {de, hs, vs};
      for (int d = 0; d < 2; d++) begin
        int w, h, addr;
        bit box, opq;
        logic [11:0] tex;
        w    = 20 << d;
        h    = 18 << d;
        box  = de && act_en && px >= act_x && px < act_x + w &&
               py >= act_y && py < act_y + h;
        addr = box ? ((py - act_y) >> d) * 20 + ((px - act_x) >> d) : 0;
        tex  = {mem_r[addr][3:0], mem_g[addr][3:0], mem_b[addr][3:0]};
        opq  = box && (tex != KEY);
        e_rgb[d][cyc]  = !de ? 12'h000 : (opq ? tex : bg);
        e_hit[d][cyc]  = opq;
        e_addr[d][cyc] = 9'(addr);
      end
    end
    cyc++;
  endtask

  // One randomized pixel, biased towards the active sprite box.
  task automatic rand_cycle(input int fs_pct, input int en_pct);
    int px, py, sx, sy;
    bit fs, sen;
    fs  = ($urandom_range(0, 99) < fs_pct);
    sen = ($urandom_range(0, 99) < en_pct);
    sx  = ($urandom_range(0, 99) < 85) ? $urandom_range(0, 600) : $urandom_range(960, 1023);
    sy  = ($urandom_range(0, 99) < 85) ? $urandom_range(0, 460) : $urandom_range(1000, 1023);
    if ($urandom_range(0, 99) < 75) begin
      px = (act_x + $urandom_range(0, 100) - 10) & 1023;
      py = (act_y + $urandom_range(0, 90) - 8) & 1023;
    end else begin
      px = $urandom_range(0, 1023);
      py = $urandom_range(0, 1023);
    end
    step(1'b1, fs, ($urandom_range(0, 9) != 0), 1'($urandom), 1'($urandom),
         px, py, 12'($urandom), sx, sy, sen);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem_r[i] = 8'($urandom);
      mem_g[i] = 8'($urandom);
      mem_b[i] = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        mem_r[i][3:0] = 4'hF; mem_g[i][3:0] = 4'hF; mem_b[i][3:0] = 4'hF;
      end
    end
    // Last texel is transparent; upper nibbles stay random on purpose.
    mem_r[359][3:0] = 4'hF; mem_g[359][3:0] = 4'hF; mem_b[359][3:0] = 4'hF;
    mem_r[0][3:0]   = 4'h3;

    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 12'h000, 0, 0, 1'b0);

    // Directed pixels around the box at (100,50), first one on frame_start.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 100, 50, 12'h123, 100, 50, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 119, 67, 12'h456, 100, 50, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 120, 50, 12'h789, 100, 50, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 100, 68, 12'hABC, 100, 50, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 103, 52, 12'h0DE, 100, 50, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 139, 85, 12'h5A5, 100, 50, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 140, 50, 12'h321, 100, 50, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 105, 55, 12'h777, 100, 50, 1'b1);
    // Requested position moves without frame_start: old box still applies.
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 101, 51, 12'h246, 300, 300, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 300, 300, 12'h246, 300, 300, 1'b1);

    for (int i = 0; i < 600; i++) rand_cycle(3, 80);

    // Re-centre, then reset mid-line with active outputs in flight.
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 200, 100, 12'h9F1, 200, 100, 1'b1);
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 201 + i, 101, 12'h9F2, 200, 100, 1'b1);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5, 5, 12'h111, 0, 0, 1'b1);
    // After release the sprite stays hidden until a frame_start.
    for (int i = 0; i < 40; i++) rand_cycle(0, 100);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10, 10, 12'h222, 0, 0, 1'b0);
    for (int i = 0; i < 40; i++) rand_cycle(0, 100);
    for (int i = 0; i < 300; i++) rand_cycle(3, 80);

    for (int i = 0; i < 6; i++)
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 12'h000, 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
